// File: rtl/lc3_mem_bridge.sv
// rtl/lc3_mem_bridge.sv - LC-3 MAR/MDR to async SRAM bridge with wait states and one MMIO word
// Strobes and R decode from registered state only, so reset clears them without a clock edge.
module lc3_mem_bridge #(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [15:0] MMIO_ADDR   = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset_ah,
   input  logic        MEM_EN,
   input  logic        WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic [15:0] SW,
   input  logic [15:0] Data_from_SRAM,
   output logic [15:0] MDR_In,
   output logic        R,
   output logic [19:0] ADDR,
   output logic [15:0] Data_to_SRAM,
   output logic        CE_N,
   output logic        OE_N,
   output logic        WE_N,
   output logic        UB_N,
   output logic        LB_N,
   output logic [15:0] HEX_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] mdr_in_q, mdr_in_d;
   logic [15:0] hex_q, hex_d;
   logic        we_q, we_d;
   logic        access;

   always_ff @(posedge Clk or posedge Reset_ah) begin
      if (Reset_ah) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mdr_in_q <= '0;
         hex_q    <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mdr_in_q <= mdr_in_d;
         hex_q    <= hex_d;
         we_q     <= we_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mdr_in_d = mdr_in_q;
      hex_d    = hex_q;
      we_d     = we_q;
      case (state_q)
         IDLE: begin
            if (MEM_EN) begin
               addr_d  = MAR;
               wdata_d = MDR;
               we_d    = WE;
               if (MAR == MMIO_ADDR) begin
                  if (WE) hex_d = MDR;
                  else    mdr_in_d = SW;
                  state_d = DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // MEM_EN is ignored here: a started access always runs to completion.
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WS) begin
               if (!we_q) mdr_in_d = Data_from_SRAM;
               state_d = DONE;
            end
         end
         DONE:    state_d = MEM_EN ? RELEASE : IDLE;
         RELEASE: if (!MEM_EN) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign access       = (state_q == ACCESS);
   assign CE_N         = ~access;
   assign UB_N         = ~access;
   assign LB_N         = ~access;
   assign OE_N         = ~(access & ~we_q);
   assign WE_N         = ~(access & we_q);
   assign R            = (state_q == DONE);
   assign ADDR         = {4'b0, addr_q};
   assign Data_to_SRAM = wdata_q;
   assign MDR_In       = mdr_in_q;
   assign HEX_out      = hex_q;

endmodule

// File: doc/lc3_mem_bridge.md
# lc3_mem_bridge

Memory-interface stage sitting directly downstream of the LC-3 datapath's MAR/MDR registers and upstream of its MIO_EN mux input. It accepts a one-word read or write request from the control unit, runs a multi-cycle access to asynchronous 16-bit SRAM with a programmable number of wait states, and returns read data on MDR_In with a one-cycle ready pulse. One address is decoded as memory-mapped I/O: reads return the switches, and writes load the hex-display register. No SRAM strobe is issued for that address.

## Interface
- WAIT_STATES, 2: extra SRAM strobe cycles beyond the first. Legal range 0..15.
- MMIO_ADDR, 16'hFFFF: address decoded as I/O instead of SRAM.

- Clk  in  1  system clock. All state changes on the rising edge.
- Reset_ah  in  1  reset. Asynchronous, active-high.
- MEM_EN  in  1  access request from the control unit. Held high until R is seen.
- WE  in  1  1 = write, 0 = read. Sampled together with MEM_EN.
- MAR  in  16  word address.
- MDR  in  16  write data.
- SW  in  16  switch inputs, returned on an MMIO read.
- Data_from_SRAM  in  16  SRAM read data.
- MDR_In  out  16  registered read data, to the datapath MDR input mux.
- R  out  1  ready. High for exactly one cycle when the access completes.
- ADDR  out  20  SRAM address, {4'b0, latched MAR}.
- Data_to_SRAM  out  16  latched write data. Tristating is done outside this block.
- CE_N, OE_N, WE_N, UB_N, LB_N  out  1 each  active-low SRAM strobes.
- HEX_out  out  16  hex-display register.

## Operation
- States:
  - IDLE
  - ACCESS
  - DONE
  - RELEASE
- IDLE, MEM_EN=1: on the edge, latch MAR, MDR and WE, then decode the address.
  - Address = MMIO_ADDR, read: MDR_In <= SW; go to DONE.
  - Address = MMIO_ADDR, write: HEX_out <= MDR; go to DONE.
  - Any other address: counter <= 0; go to ACCESS.
- ACCESS:
  - CE_N=UB_N=LB_N=0.
  - Read: OE_N=0, WE_N=1.
  - Write: WE_N=0, OE_N=1.
  - Counter increments each edge.
  - On the edge where counter==WAIT_STATES: read latches MDR_In <= Data_from_SRAM, write leaves MDR_In unchanged; go to DONE.
- DONE: R=1, all strobes high. The next edge goes to RELEASE if MEM_EN=1, or to IDLE if MEM_EN=0.
- RELEASE: wait for MEM_EN=0, then go to IDLE. This prevents a held MEM_EN from causing a second access.
- MEM_EN dropping during ACCESS does not abort the access. The access completes and R still pulses.
- Strobes, R and ADDR are driven from registered state only, so there are no combinational paths from the inputs.
- Counter is 4 bits. WAIT_STATES=0 gives a single-cycle strobe.

## Timing
- Reset values:
  - State: IDLE.
  - R: 0.
  - CE_N, OE_N, WE_N, UB_N, LB_N: all 1.
  - ADDR, Data_to_SRAM, MDR_In, HEX_out: all 0.
  - Counter: 0.
- Reset asserted mid-access deasserts all strobes immediately, without waiting for a clock edge.
- Edge 0 is the sampling edge, where IDLE sees MEM_EN=1.
- SRAM access:
  - Strobes are low from edge 0 to edge WAIT_STATES+1, which is WAIT_STATES+1 cycles.
  - R is high from edge WAIT_STATES+1 to edge WAIT_STATES+2.
  - MDR_In is valid from edge WAIT_STATES+1 and holds until the next read.
- MMIO access: R is high from edge 0 to edge 1. MDR_In or HEX_out updates at edge 0. Strobes never assert.
- ADDR and Data_to_SRAM are stable for the whole strobe window. WE_N and OE_N never go low together.
- After R, the earliest next sampling edge is edge WAIT_STATES+3, which requires MEM_EN=0 during DONE.

## Test plan
- SRAM read, WAIT_STATES=2:
  - Stimulus: MAR=16'h3000, SRAM returns 16'hBEEF.
  - Strobes: CE_N/OE_N low for 3 cycles.
  - R: high during the 4th cycle after edge 0.
  - Result: MDR_In=16'hBEEF. WE_N stays 1.
- SRAM write:
  - Stimulus: MAR=16'h0010, MDR=16'h1234.
  - Bus: ADDR=20'h00010 and Data_to_SRAM=16'h1234 held while WE_N=0 for 3 cycles.
  - Strobes: OE_N stays 1.
  - Result: R pulses once and MDR_In is unchanged.
- MMIO read:
  - Stimulus: MAR=16'hFFFF, SW=16'h00A5.
  - Result: R high the cycle after edge 0, MDR_In=16'h00A5, CE_N stays 1 throughout.
- MMIO write:
  - Stimulus: MAR=16'hFFFF, WE=1, MDR=16'hC0DE.
  - Result: HEX_out=16'hC0DE after edge 0, R pulses once, no SRAM strobe.
- MEM_EN held high for 10 cycles after R:
  - Required: exactly one R pulse and one strobe window.
  - Dropping MEM_EN for one cycle, then raising it again, starts a second access.
- Reset mid-access:
  - Stimulus: assert Reset_ah between clock edges during cycle 2 of ACCESS.
  - Required: CE_N/OE_N return to 1 immediately, R=0, MDR_In=0, state=IDLE.
  - After release, a new read completes normally.
